// File: rtl/sa_feeder.sv
// Purpose : turns unskewed ifmap/weight vectors into the diagonal wavefront a systolic array expects.
// Latency : lane r (c) reaches its tail r+1 (c+1) advances after the beat is accepted; o_pe_en follows by one cycle.
// Backpressure: o_ready is high only in FEED; a FEED cycle with i_valid low freezes every skew chain.
//
// Ports:
//   i_clk, i_nrst         clock and asynchronous active-low reset
//   i_start, i_k_len      tile start pulse (honoured only in IDLE) and beat count latched with it
//   i_valid / o_ready     beat handshake for i_ifmap (one element per row) and i_weight (one per column)
//   o_ifmap, o_weight     skew chain tails driven to the array edges
//   o_pe_en, o_reg_clear  PE enable and accumulator clear
//   o_busy, o_done        not-IDLE flag and end-of-tile pulse
module sa_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int S_WIDTH    = 2,
  parameter int S_HEIGHT   = 2
) (
  input  logic                                  i_clk,
  input  logic                                  i_nrst,
  input  logic                                  i_start,
  input  logic [15:0]                           i_k_len,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [0:S_HEIGHT-1][DATA_WIDTH-1:0]   i_ifmap,
  input  logic [0:S_WIDTH-1][DATA_WIDTH-1:0]    i_weight,
  output logic [0:S_HEIGHT-1][DATA_WIDTH-1:0]   o_ifmap,
  output logic [0:S_WIDTH-1][DATA_WIDTH-1:0]    o_weight,
  output logic                                  o_pe_en,
  output logic                                  o_reg_clear,
  output logic                                  o_busy,
  output logic                                  o_done
);

  // Zeros pushed through FLUSH must reach the far corner of the array.
  localparam int FLUSH_LEN = S_HEIGHT + S_WIDTH - 1;
  localparam int FC_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t          state;
  logic [15:0]     k_len;
  logic [15:0]     beat_cnt;
  logic [FC_W-1:0] flush_cnt;
  logic            pe_en_q;
  logic            reg_clear_q;

  logic accept;
  logic advance;

  assign accept  = (state == FEED) && i_valid;
  assign advance = accept || (state == FLUSH);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= IDLE;
      k_len       <= '0;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      pe_en_q     <= 1'b0;
      reg_clear_q <= 1'b0;
    end else begin
      reg_clear_q <= 1'b0;
      // Tails change on the edge that performs an advance, so the enable is the advance one cycle late.
      pe_en_q     <= advance;
      case (state)
        IDLE: begin
          if (i_start) begin
            k_len       <= i_k_len;
            beat_cnt    <= '0;
            reg_clear_q <= 1'b1;
            state       <= (i_k_len == 16'd0) ? DONE : FEED;
          end
        end
        FEED: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (beat_cnt + 16'd1 == k_len) begin
              flush_cnt <= '0;
              state     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) state <= DONE;
          else                         flush_cnt <= flush_cnt + FC_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Row r needs r+1 stages so that element r of a beat arrives r cycles after element 0.
  for (genvar r = 0; r < S_HEIGHT; r++) begin : g_row
    logic [r:0][DATA_WIDTH-1:0] chain;
    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        chain <= '0;
      end else if (advance) begin
        chain[0] <= accept ? i_ifmap[r] : '0;
        for (int j = 1; j <= r; j++) chain[j] <= chain[j-1];
      end
    end
    assign o_ifmap[r] = chain[r];
  end

  for (genvar c = 0; c < S_WIDTH; c++) begin : g_col
    logic [c:0][DATA_WIDTH-1:0] chain;
    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        chain <= '0;
      end else if (advance) begin
        chain[0] <= accept ? i_weight[c] : '0;
        for (int j = 1; j <= c; j++) chain[j] <= chain[j-1];
      end
    end
    assign o_weight[c] = chain[c];
  end

  assign o_ready     = (state == FEED);
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);
  assign o_pe_en     = pe_en_q;
  assign o_reg_clear = reg_clear_q;

endmodule

// File: tb/tb_sa_feeder.sv
// Bench for sa_feeder: a 2x2 instance (a_*) and a 4x3 instance (b_*) share clock and reset.
// Lane scoreboards are filled as beats are driven and drained on o_pe_en cycles.
// Tile-level counters (FLUSH cycles, PE enables, done pulses) are checked after each tile.
module tb_sa_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst;

  logic             a_start, a_valid, a_ready, a_pe_en, a_reg_clear, a_busy, a_done;
  logic [15:0]      a_k_len;
  logic [0:1][7:0]  a_ifmap, a_oifmap;
  logic [0:1][7:0]  a_weight, a_oweight;

  logic             b_start, b_valid, b_ready, b_pe_en, b_reg_clear, b_busy, b_done;
  logic [15:0]      b_k_len;
  logic [0:3][7:0]  b_ifmap, b_oifmap;
  logic [0:2][7:0]  b_weight, b_oweight;

  sa_feeder #(.DATA_WIDTH(8), .S_WIDTH(2), .S_HEIGHT(2)) u_dut_a (
    .i_clk(clk), .i_nrst(nrst), .i_start(a_start), .i_k_len(a_k_len),
    .i_valid(a_valid), .o_ready(a_ready), .i_ifmap(a_ifmap), .i_weight(a_weight),
    .o_ifmap(a_oifmap), .o_weight(a_oweight), .o_pe_en(a_pe_en),
    .o_reg_clear(a_reg_clear), .o_busy(a_busy), .o_done(a_done)
  );

  sa_feeder #(.DATA_WIDTH(8), .S_WIDTH(3), .S_HEIGHT(4)) u_dut_b (
    .i_clk(clk), .i_nrst(nrst), .i_start(b_start), .i_k_len(b_k_len),
    .i_valid(b_valid), .o_ready(b_ready), .i_ifmap(b_ifmap), .i_weight(b_weight),
    .o_ifmap(b_oifmap), .o_weight(b_oweight), .o_pe_en(b_pe_en),
    .o_reg_clear(b_reg_clear), .o_busy(b_busy), .o_done(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Per-lane scoreboards and tile statistics.
  logic [7:0] a_qif [2][$];
  logic [7:0] a_qw  [2][$];
  logic [7:0] b_qif [4][$];
  logic [7:0] b_qw  [3][$];
  logic [7:0] a_lif [2] = '{default: '0};
  logic [7:0] a_lw  [2] = '{default: '0};
  logic [7:0] b_lif [4] = '{default: '0};
  logic [7:0] b_lw  [3] = '{default: '0};
  int a_k = 0, b_k = 0, a_adv = -1, b_adv = -1;
  int a_flush_n = 0, a_pe_n = 0, a_run = 0, a_maxrun = 0, a_done_n = 0, a_clr_n = 0;
  int b_flush_n = 0, b_pe_n = 0, b_run = 0, b_maxrun = 0, b_done_n = 0, b_clr_n = 0;

  // Lane L holds beat (adv - L) when 0 <= adv-L < k, else a flushed zero; between advances it holds.
  always @(negedge clk) begin
    if (!nrst) begin
      a_adv = -1;
      foreach (a_lif[r]) a_lif[r] = '0;
      foreach (a_lw[c])  a_lw[c]  = '0;
    end else begin
      if (a_reg_clear) begin
        a_adv = -1; a_flush_n = 0; a_pe_n = 0; a_run = 0; a_maxrun = 0; a_done_n = 0; a_clr_n++;
      end
      if (a_busy && !a_ready && !a_done) a_flush_n++;
      if (a_done) a_done_n++;
      if (a_pe_en) begin
        a_pe_n++; a_run++; a_adv++;
        if (a_run > a_maxrun) a_maxrun = a_run;
        for (int r = 0; r < 2; r++) begin
          if (a_adv >= r && a_adv < r + a_k) begin
            if (a_qif[r].size() != 0) a_lif[r] = a_qif[r].pop_front(); else a_lif[r] = 'x;
            if (a_qw[r].size() != 0)  a_lw[r]  = a_qw[r].pop_front();  else a_lw[r]  = 'x;
          end else begin
            a_lif[r] = '0; a_lw[r] = '0;
          end
        end
      end else a_run = 0;
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("a_ifmap_tail%0d", r), a_oifmap[r], a_lif[r]);
        chk($sformatf("a_weight_tail%0d", r), a_oweight[r], a_lw[r]);
      end
    end
  end

  always @(negedge clk) begin
    if (!nrst) begin
      b_adv = -1;
      foreach (b_lif[r]) b_lif[r] = '0;
      foreach (b_lw[c])  b_lw[c]  = '0;
    end else begin
      if (b_reg_clear) begin
        b_adv = -1; b_flush_n = 0; b_pe_n = 0; b_run = 0; b_maxrun = 0; b_done_n = 0; b_clr_n++;
      end
      if (b_busy && !b_ready && !b_done) b_flush_n++;
      if (b_done) b_done_n++;
      if (b_pe_en) begin
        b_pe_n++; b_run++; b_adv++;
        if (b_run > b_maxrun) b_maxrun = b_run;
        for (int r = 0; r < 4; r++) begin
          if (b_adv >= r && b_adv < r + b_k) begin
            if (b_qif[r].size() != 0) b_lif[r] = b_qif[r].pop_front(); else b_lif[r] = 'x;
          end else b_lif[r] = '0;
        end
        for (int c = 0; c < 3; c++) begin
          if (b_adv >= c && b_adv < c + b_k) begin
            if (b_qw[c].size() != 0) b_lw[c] = b_qw[c].pop_front(); else b_lw[c] = 'x;
          end else b_lw[c] = '0;
        end
      end else b_run = 0;
      for (int r = 0; r < 4; r++) chk($sformatf("b_ifmap_tail%0d", r), b_oifmap[r], b_lif[r]);
      for (int c = 0; c < 3; c++) chk($sformatf("b_weight_tail%0d", c), b_oweight[c], b_lw[c]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [7:0] i0, input logic [7:0] i1,
                         input logic [7:0] w0, input logic [7:0] w1);
    a_valid  = 1'b1;
    a_ifmap  = {i0, i1};
    a_weight = {w0, w1};
    a_qif[0].push_back(i0); a_qif[1].push_back(i1);
    a_qw[0].push_back(w0);  a_qw[1].push_back(w1);
  endtask

  task automatic drive_a_rand();
    drive_a(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
            8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
  endtask

  task automatic drive_b_rand();
    logic [7:0] v;
    b_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      v = 8'($urandom_range(1, 255)); b_ifmap[r] = v; b_qif[r].push_back(v);
    end
    for (int c = 0; c < 3; c++) begin
      v = 8'($urandom_range(1, 255)); b_weight[c] = v; b_qw[c].push_back(v);
    end
  endtask

  task automatic start_a(input int k);
    a_k = k; a_k_len = 16'(k); a_start = 1'b1;
  endtask

  // Steps until o_busy drops (bounded) and checks it drops in the cycle after o_done.
  task automatic wait_idle(input bit sel);
    logic prev_done = 1'b0;
    int   n = 0;
    while ((sel ? b_busy : a_busy) && n < 200) begin
      prev_done = sel ? b_done : a_done;
      step();
      n++;
    end
    chk(sel ? "b_idle_timeout" : "a_idle_timeout", sel ? b_busy : a_busy, 0);
    chk(sel ? "b_busy_after_done" : "a_busy_after_done", prev_done, 1);
  endtask

  task automatic chk_tile_a(input int exp_flush, input int exp_pe);
    chk("a_flush_cycles", a_flush_n, exp_flush);
    chk("a_pe_en_cycles", a_pe_n, exp_pe);
    chk("a_done_pulses", a_done_n, 1);
    chk("a_sb_leftover", a_qif[0].size() + a_qif[1].size() + a_qw[0].size() + a_qw[1].size(), 0);
  endtask

  initial begin
    int clr0;
    nrst = 1'b1;
    a_start = 0; a_k_len = '0; a_valid = 0; a_ifmap = '0; a_weight = '0;
    b_start = 0; b_k_len = '0; b_valid = 0; b_ifmap = '0; b_weight = '0;
    #2 nrst = 1'b0;
    #10;
    chk("a_reset_outputs", {a_oifmap, a_oweight, a_ready, a_pe_en, a_reg_clear, a_busy, a_done}, 0);
    chk("b_reset_outputs", {b_oifmap, b_oweight, b_ready, b_pe_en, b_reg_clear, b_busy, b_done}, 0);
    step(); step();
    nrst = 1'b1;
    step();

    // k_len=1, single beat {3,5}/{7,9}, i_valid held high.
    start_a(1);
    drive_a(8'd3, 8'd5, 8'd7, 8'd9);
    step();
    a_start = 1'b0;
    chk("t1_reg_clear", a_reg_clear, 1);
    chk("t1_ready_feed", a_ready, 1);
    chk("t1_busy", a_busy, 1);
    chk("t1_pe_en_before_beat", a_pe_en, 0);
    step();
    chk("t1_pe_en_first", a_pe_en, 1);
    chk("t1_reg_clear_once", a_reg_clear, 0);
    chk("t1_ready_flush", a_ready, 0);
    chk("t1_tails_adv1", {a_oifmap, a_oweight}, {8'd3, 8'd0, 8'd7, 8'd0});
    step();
    chk("t1_tails_adv2", {a_oifmap, a_oweight}, {8'd0, 8'd5, 8'd0, 8'd9});
    wait_idle(0);
    a_valid = 1'b0;
    chk_tile_a(3, 4);

    // k_len=3 with a two-cycle i_valid gap between the second and third beat.
    start_a(3);
    step();
    a_start = 1'b0;
    drive_a_rand(); step();
    chk("t2_pe_en_beat0", a_pe_en, 1);
    drive_a_rand(); step();
    chk("t2_pe_en_beat1", a_pe_en, 1);
    a_valid = 1'b0; step();
    chk("t2_pe_en_stall0", a_pe_en, 0);
    chk("t2_ready_stall", a_ready, 1);
    step();
    chk("t2_pe_en_stall1", a_pe_en, 0);
    drive_a_rand(); step();
    chk("t2_pe_en_beat2", a_pe_en, 1);
    a_valid = 1'b0;
    wait_idle(0);
    chk_tile_a(3, 6);

    // k_len=0: straight to DONE, no FEED, no FLUSH.
    start_a(0);
    step();
    a_start = 1'b0;
    chk("t3_reg_clear", a_reg_clear, 1);
    chk("t3_done", a_done, 1);
    chk("t3_ready", a_ready, 0);
    wait_idle(0);
    chk("t3_pe_en_cycles", a_pe_n, 0);
    chk("t3_flush_cycles", a_flush_n, 0);
    chk("t3_done_pulses", a_done_n, 1);

    // Start pulses during FEED and FLUSH, each with a different k_len, must be ignored.
    clr0 = a_clr_n;
    start_a(3);
    step();
    a_start = 1'b0;
    drive_a_rand(); step();
    drive_a_rand(); a_start = 1'b1; a_k_len = 16'd9; step();
    a_start = 1'b0;
    drive_a_rand(); step();
    chk("t4_in_flush", a_ready, 0);
    a_valid = 1'b0; a_start = 1'b1; a_k_len = 16'd1; step();
    a_start = 1'b0;
    wait_idle(0);
    chk_tile_a(3, 6);
    chk("t4_reg_clear_pulses", a_clr_n - clr0, 1);

    // Reset dropped mid-FLUSH with data in the chains, between clock edges.
    start_a(2);
    step();
    a_start = 1'b0;
    drive_a_rand(); step();
    drive_a_rand(); step();
    a_valid = 1'b0; step();
    chk("t5_chain_loaded", a_oifmap != '0, 1);
    #1 nrst = 1'b0;
    #1;
    chk("t5_async_reset_outputs", {a_oifmap, a_oweight, a_ready, a_pe_en, a_reg_clear, a_busy, a_done}, 0);
    for (int r = 0; r < 2; r++) begin a_qif[r].delete(); a_qw[r].delete(); end
    step(); step();
    nrst = 1'b1;
    step(); step(); step(); step();
    chk("t5_no_done_after_reset", a_done_n, 0);
    chk("t5_idle_after_reset", a_busy, 0);
    start_a(2);
    step();
    a_start = 1'b0;
    chk("t5_fresh_reg_clear", a_reg_clear, 1);
    drive_a_rand(); step();
    drive_a_rand(); step();
    a_valid = 1'b0;
    wait_idle(0);
    chk_tile_a(3, 5);

    // 4x3 instance, k_len=5, continuous beats.
    b_k = 5; b_k_len = 16'd5; b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("t6_reg_clear", b_reg_clear, 1);
    for (int n = 0; n < 5; n++) begin
      drive_b_rand();
      step();
    end
    b_valid = 1'b0;
    wait_idle(1);
    chk("t6_flush_cycles", b_flush_n, 6);
    chk("t6_pe_en_cycles", b_pe_n, 11);
    chk("t6_pe_en_run", b_maxrun, 11);
    chk("t6_done_pulses", b_done_n, 1);
    chk("t6_sb_leftover", b_qif[0].size() + b_qif[1].size() + b_qif[2].size() + b_qif[3].size()
                        + b_qw[0].size() + b_qw[1].size() + b_qw[2].size(), 0);

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
